// File: rtl/affine_loader_pkg.sv
// affine_loader_pkg: widths, FSM state encoding and word-count helper shared by
// the affine loader, its interface and the ctrl debug view.
package affine_loader_pkg;

  localparam int W_CHANNEL      = 8;
  localparam int BIAS_BUFFER_AW = 10;
  localparam int AFFINE_AW      = BIAS_BUFFER_AW;
  localparam int AXI_WIDTH_DA   = 32;
  localparam int AXI_WIDTH_AD   = 32;
  localparam int LEN_W          = AFFINE_AW + 1;
  localparam int TO_CYCLES_DEF  = 4096;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_B_ARM   = 4'd1,
    ST_B_REQ   = 4'd2,
    ST_B_DAT   = 4'd3,
    ST_GAP     = 4'd4,
    ST_S_ARM   = 4'd5,
    ST_S_REQ   = 4'd6,
    ST_S_DAT   = 4'd7,
    ST_WAIT_PP = 4'd8,
    ST_DONE    = 4'd9
  } state_t;

  // Tout = 4 output lanes per tiled channel, so each phase moves 4*ch words.
  function automatic logic [LEN_W-1:0] word_count(input logic [W_CHANNEL-1:0] ch);
    return LEN_W'({ch, 2'b00});
  endfunction

endpackage

// File: rtl/affine_loader_if.sv
// affine_loader_if: ctrl start/status, DMA read channel and postprocessor
// affine-load port of affine_loader, bundled with master (loader) / slave views.
interface affine_loader_if;
  import affine_loader_pkg::*;

  // Handshakes: o_dma_rd_req with o_dma_rd_addr/o_dma_rd_len is held stable
  // until i_dma_rd_ack is sampled high, and that edge is the one transfer
  // (ack may already be high the cycle req rises). Beats have no back-pressure:
  // every cycle with i_dma_rd_vld=1 carries one word; read_data_vld marks one
  // registered word for the postprocessor, o_pp_load_done is a 1-cycle pulse.
  logic                    c_affine_start;
  logic [W_CHANNEL-1:0]    q_channel_out;
  logic [AXI_WIDTH_AD-1:0] q_bias_base;
  logic [AXI_WIDTH_AD-1:0] q_scale_base;

  logic                    o_dma_rd_req;
  logic [AXI_WIDTH_AD-1:0] o_dma_rd_addr;
  logic [LEN_W-1:0]        o_dma_rd_len;
  logic                    i_dma_rd_ack;
  logic [AXI_WIDTH_DA-1:0] i_dma_rd_data;
  logic                    i_dma_rd_vld;

  logic                    q_load_bias;
  logic                    q_load_scale;
  logic [AXI_WIDTH_DA-1:0] read_data;
  logic                    read_data_vld;
  logic                    o_pp_load_done;

  logic                    o_affine_busy;
  logic                    o_affine_done;
  logic                    o_affine_err;

  modport master (
    input  c_affine_start, q_channel_out, q_bias_base, q_scale_base,
    input  i_dma_rd_ack, i_dma_rd_data, i_dma_rd_vld, o_pp_load_done,
    output o_dma_rd_req, o_dma_rd_addr, o_dma_rd_len,
    output q_load_bias, q_load_scale, read_data, read_data_vld,
    output o_affine_busy, o_affine_done, o_affine_err
  );

  modport slave (
    output c_affine_start, q_channel_out, q_bias_base, q_scale_base,
    output i_dma_rd_ack, i_dma_rd_data, i_dma_rd_vld, o_pp_load_done,
    input  o_dma_rd_req, o_dma_rd_addr, o_dma_rd_len,
    input  q_load_bias, q_load_scale, read_data, read_data_vld,
    input  o_affine_busy, o_affine_done, o_affine_err
  );

endinterface

// File: rtl/affine_loader.sv
// affine_loader: per-layer bias-then-scale fetch sequencer feeding the postprocessor.
// Optional watchdog: define AFFINE_LD_TIMEOUT_EN to enable the TO_CYCLES stall timeout.
module affine_loader
  import affine_loader_pkg::*;
#(
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  affine_loader_if.master io_bus,
  output state_t          o_dbg_state
);

  state_t                  r_state;
  state_t                  w_next;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_beat_cnt;
  logic [AXI_WIDTH_AD-1:0] r_bias_base;
  logic [AXI_WIDTH_AD-1:0] r_scale_base;
  logic [AXI_WIDTH_DA-1:0] r_read_data;
  logic                    r_read_data_vld;

  logic                    w_start;
  logic                    w_in_req;
  logic                    w_in_dat;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_timeout;
  logic                    w_err;

  logic                    w_req;
  logic [AXI_WIDTH_AD-1:0] w_addr;
  logic [LEN_W-1:0]        w_len;
  logic                    w_load_bias;
  logic                    w_load_scale;
  logic                    w_busy;
  logic                    w_done;

  assign w_start  = (r_state == ST_IDLE) && io_bus.c_affine_start;
  assign w_in_req = (r_state == ST_B_REQ) || (r_state == ST_S_REQ);
  assign w_in_dat = (r_state == ST_B_DAT) || (r_state == ST_S_DAT);
  // Only beats inside a data state are taken; r_len is never 0 there.
  assign w_accept = w_in_dat && io_bus.i_dma_rd_vld;
  assign w_last   = w_accept && (r_beat_cnt == (r_len - LEN_W'(1)));

`ifdef AFFINE_LD_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;
  logic            w_watch;
  logic            w_progress;

  assign w_watch    = w_in_req || w_in_dat || (r_state == ST_WAIT_PP);
  assign w_progress = io_bus.i_dma_rd_vld || io_bus.i_dma_rd_ack || io_bus.o_pp_load_done;
  assign w_timeout  = w_watch && !w_progress && (r_wd_cnt == WD_W'(TO_CYCLES - 1));
  assign w_err      = r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (!w_watch || w_progress) r_wd_cnt <= '0;
      else                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      // Sticky until the next accepted start.
      if (w_start)        r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = (TO_CYCLES != 0);
  assign w_timeout   = 1'b0;
  assign w_err       = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    w_req        = 1'b0;
    w_addr       = '0;
    w_len        = '0;
    w_load_bias  = 1'b0;
    w_load_scale = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (io_bus.c_affine_start) begin
          w_next = (word_count(io_bus.q_channel_out) == '0) ? ST_DONE : ST_B_ARM;
        end
      end
      ST_B_ARM: begin
        w_load_bias = 1'b1;
        w_next      = ST_B_REQ;
      end
      ST_B_REQ: begin
        w_load_bias = 1'b1;
        w_req       = 1'b1;
        w_addr      = r_bias_base;
        w_len       = r_len;
        if (io_bus.i_dma_rd_ack) w_next = ST_B_DAT;
      end
      ST_B_DAT: begin
        w_load_bias = 1'b1;
        if (w_last) w_next = ST_GAP;
      end
      // Both levels low for one cycle so the postprocessor sees a fresh scale edge.
      ST_GAP: w_next = ST_S_ARM;
      ST_S_ARM: begin
        w_load_scale = 1'b1;
        w_next       = ST_S_REQ;
      end
      ST_S_REQ: begin
        w_load_scale = 1'b1;
        w_req        = 1'b1;
        w_addr       = r_scale_base;
        w_len        = r_len;
        if (io_bus.i_dma_rd_ack) w_next = ST_S_DAT;
      end
      ST_S_DAT: begin
        w_load_scale = 1'b1;
        if (w_last) w_next = ST_WAIT_PP;
      end
      ST_WAIT_PP: begin
        w_load_scale = 1'b1;
        if (io_bus.o_pp_load_done) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
    if (w_timeout) w_next = ST_DONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= ST_IDLE;
      r_len           <= '0;
      r_bias_base     <= '0;
      r_scale_base    <= '0;
      r_beat_cnt      <= '0;
      r_read_data     <= '0;
      r_read_data_vld <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_len        <= word_count(io_bus.q_channel_out);
        r_bias_base  <= io_bus.q_bias_base;
        r_scale_base <= io_bus.q_scale_base;
      end
      if (w_last || !w_in_dat) r_beat_cnt <= '0;
      else if (w_accept)       r_beat_cnt <= r_beat_cnt + LEN_W'(1);
      r_read_data_vld <= w_accept;
      if (w_accept) r_read_data <= io_bus.i_dma_rd_data;
    end
  end

  assign io_bus.o_dma_rd_req  = w_req;
  assign io_bus.o_dma_rd_addr = w_addr;
  assign io_bus.o_dma_rd_len  = w_len;
  assign io_bus.q_load_bias   = w_load_bias;
  assign io_bus.q_load_scale  = w_load_scale;
  assign io_bus.read_data     = r_read_data;
  assign io_bus.read_data_vld = r_read_data_vld;
  assign io_bus.o_affine_busy = w_busy;
  assign io_bus.o_affine_done = w_done;
  assign io_bus.o_affine_err  = w_err;
  assign o_dbg_state          = r_state;

endmodule
